// File: rtl/key_mode_ctrl.sv
// Push-button front end: synchronise, debounce, and step the LED pattern-select bus on each press.
// Optional `LONG_PRESS_RESET_EN: a hold of LONG_CYCLES forces ctrl back to 0 with an extra strobe.
module key_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 540000,
    parameter int unsigned MODE_NUM        = 3,
    parameter int unsigned LONG_CYCLES     = 27000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic [1:0] ctrl,
    output logic       key_pulse,
    output logic       key_state
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1048575 || MODE_NUM < 2 || MODE_NUM > 4 ||
        LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
        $error("key_mode_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} state_e;

    localparam logic [19:0] DbLast   = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]  CtrlLast = 2'(MODE_NUM - 1);

    state_e      r_state, w_state_d;
    logic [19:0] r_cnt, w_cnt_d;
    logic [1:0]  r_ctrl, w_ctrl_d, w_ctrl_step;
    logic        r_pulse, w_pulse_d;
    logic        r_key_state, w_key_state_d;
    logic        r_s1, r_key_s;

`ifdef LONG_PRESS_RESET_EN
    localparam int unsigned  LongW    = $clog2(LONG_CYCLES);
    localparam logic [LongW-1:0] LongLast = LongW'(LONG_CYCLES - 1);

    // Separate from r_cnt so a release bounce does not lose the hold time.
    logic [LongW-1:0] r_long, w_long_d;
`endif

    assign w_ctrl_step = (r_ctrl == CtrlLast) ? 2'd0 : r_ctrl + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1        <= 1'b1;
            r_key_s     <= 1'b1;
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_ctrl      <= 2'd0;
            r_pulse     <= 1'b0;
            r_key_state <= 1'b0;
        end else begin
            r_s1        <= key_in;
            r_key_s     <= r_s1;
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_ctrl      <= w_ctrl_d;
            r_pulse     <= w_pulse_d;
            r_key_state <= w_key_state_d;
        end
    end

`ifdef LONG_PRESS_RESET_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_long <= '0;
        end else begin
            r_long <= w_long_d;
        end
    end
`endif

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_ctrl_d      = r_ctrl;
        w_pulse_d     = 1'b0;
        w_key_state_d = r_key_state;
`ifdef LONG_PRESS_RESET_EN
        w_long_d      = r_long;
`endif
        unique case (r_state)
            StIdle: begin
                if (!r_key_s) begin
                    w_state_d = StPressDb;
                    w_cnt_d   = '0;
                end
            end
            StPressDb: begin
                if (r_key_s) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (r_cnt == DbLast) begin
                    w_state_d     = StHeld;
                    w_cnt_d       = '0;
                    w_pulse_d     = 1'b1;
                    w_key_state_d = 1'b1;
                    w_ctrl_d      = w_ctrl_step;
`ifdef LONG_PRESS_RESET_EN
                    w_long_d      = '0;
`endif
                end else begin
                    w_cnt_d = r_cnt + 20'd1;
                end
            end
            StHeld: begin
                if (r_key_s) begin
                    w_state_d = StRelDb;
                    w_cnt_d   = '0;
                end
`ifdef LONG_PRESS_RESET_EN
                // Saturating count: the strobe fires only on the edge it reaches the limit.
                else if (r_long != LongLast) begin
                    w_long_d = r_long + LongW'(1);
                    if (w_long_d == LongLast) begin
                        w_ctrl_d  = 2'd0;
                        w_pulse_d = 1'b1;
                    end
                end
`endif
            end
            StRelDb: begin
                if (!r_key_s) begin
                    w_state_d = StHeld;
                    w_cnt_d   = '0;
                end else if (r_cnt == DbLast) begin
                    w_state_d     = StIdle;
                    w_cnt_d       = '0;
                    w_key_state_d = 1'b0;
                end else begin
                    w_cnt_d = r_cnt + 20'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign ctrl      = r_ctrl;
    assign key_pulse = r_pulse;
    assign key_state = r_key_state;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Bench for key_mode_ctrl: scripted phase table, hand sequences, then random presses vs. a run-length model.
module tb_key_mode_ctrl;

    localparam int D = 16;
    localparam int L = 64;
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_in = 1'b1;
    logic [1:0] ctrl;
    logic       key_pulse;
    logic       key_state;

    key_mode_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .MODE_NUM       (M),
        .LONG_CYCLES    (L)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .ctrl     (ctrl),
        .key_pulse(key_pulse),
        .key_state(key_state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: level flips after D+1 consecutive disagreeing synchronised samples.
    int m_s1 = 1, m_ks = 1, m_prev = 1;
    int m_level = 0, m_run = 0, m_long = 0, m_ctrl = 0, m_pulse = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input int r);
        int ks;
        if (r == 0) begin
            m_s1 = 1; m_ks = 1; m_prev = 1;
            m_level = 0; m_run = 0; m_long = 0; m_ctrl = 0; m_pulse = 0;
        end else begin
            ks = m_ks;
            m_pulse = 0;
`ifdef LONG_PRESS_RESET_EN
            if (m_level == 1 && ks == 0 && m_prev == 0 && m_long < L - 1) begin
                m_long++;
                if (m_long == L - 1) begin
                    m_ctrl  = 0;
                    m_pulse = 1;
                end
            end
`endif
            if ((ks == 0 ? 1 : 0) != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = (ks == 0) ? 1 : 0;
                    m_run   = 0;
                    if (m_level == 1) begin
                        m_pulse = 1;
                        m_ctrl  = (m_ctrl + 1) % M;
                        m_long  = 0;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_prev = ks;
            m_ks   = m_s1;
            m_s1   = k;
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare away from the edge.
    task automatic tick(input logic k, input logic r);
        key_in = k;
        rst_n  = r;
        @(posedge clk);
        model_edge(int'(k), int'(r));
        #1;
        chk("model_ctrl", int'(ctrl), m_ctrl);
        chk("model_pulse", int'(key_pulse), m_pulse);
        chk("model_state", int'(key_state), m_level);
    endtask

    task automatic run_phase(input logic k, input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int i = 0; i < n; i++) begin
            tick(k, 1'b1);
            if (key_pulse) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    typedef struct {
        logic key;
        int   cycles;
        int   pulses;
        int   first;
        int   ctrl;
        int   kstate;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic k, input int n, input int p, input int f,
                                input int c, input int s);
        vec_t v;
        v.key = k; v.cycles = n; v.pulses = p; v.first = f; v.ctrl = c; v.kstate = s;
        tbl.push_back(v);
    endfunction

    initial begin
        int p, f, lp, cyc, len;
        logic k;

`ifdef LONG_PRESS_RESET_EN
        lp = 2;
`else
        lp = 1;
`endif
        // Clean press straight out of reset, then release.
        add(1'b0, 40, 1, 18, 1, 1);
        add(1'b1, 40, 0, -1, 1, 0);
        // Press bounce: 5-cycle toggles never confirm.
        for (int i = 0; i < 6; i++) begin
            add(1'b0, 5, 0, -1, 1, 0);
            add(1'b1, 5, 0, -1, 1, 0);
        end
        add(1'b1, 30, 0, -1, 1, 0);
        // Four press/release pairs walk ctrl through the wrap.
        add(1'b0, 30, 1, 18, 2, 1); add(1'b1, 30, 0, -1, 2, 0);
        add(1'b0, 30, 1, 18, 0, 1); add(1'b1, 30, 0, -1, 0, 0);
        add(1'b0, 30, 1, 18, 1, 1); add(1'b1, 30, 0, -1, 1, 0);
        add(1'b0, 30, 1, 18, 2, 1); add(1'b1, 30, 0, -1, 2, 0);
        // Release bounce: key_state must hold until 18 edges after the final rise.
        add(1'b0, 30, 1, 18, 0, 1);
        add(1'b1, 5, 0, -1, 0, 1);
        add(1'b0, 3, 0, -1, 0, 1);
        add(1'b1, 18, 0, -1, 0, 1);
        add(1'b1, 12, 0, -1, 0, 0);
        // Long hold starting from ctrl=2.
        add(1'b0, 30, 1, 18, 1, 1); add(1'b1, 30, 0, -1, 1, 0);
        add(1'b0, 30, 1, 18, 2, 1); add(1'b1, 30, 0, -1, 2, 0);
        add(1'b0, 120, lp, 18, 0, 1);
        add(1'b1, 30, 0, -1, 0, 0);

        // Reset held with the button down.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            chk("rst_ctrl", int'(ctrl), 0);
            chk("rst_pulse", int'(key_pulse), 0);
            chk("rst_state", int'(key_state), 0);
        end

        foreach (tbl[i]) begin
            run_phase(tbl[i].key, tbl[i].cycles, p, f);
            chk($sformatf("vec%0d_pulses", i), p, tbl[i].pulses);
            chk($sformatf("vec%0d_first", i), f, tbl[i].first);
            chk($sformatf("vec%0d_ctrl", i), int'(ctrl), tbl[i].ctrl);
            chk($sformatf("vec%0d_state", i), int'(key_state), tbl[i].kstate);
        end

        // Reset during a press debounce discards it.
        run_phase(1'b0, 10, p, f);
        chk("midpress_nopulse", p, 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("midrst_ctrl", int'(ctrl), 0);
        chk("midrst_state", int'(key_state), 0);
        run_phase(1'b1, 30, p, f);
        chk("midrst_after_pulses", p, 0);
        chk("midrst_after_ctrl", int'(ctrl), 0);

        // Random press patterns, checked cycle by cycle against the model.
        cyc = 0;
        while (cyc < 6000) begin
            if ($urandom_range(0, 39) == 0) begin
                len = $urandom_range(1, 2);
                for (int i = 0; i < len; i++) tick(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                k   = 1'($urandom_range(0, 1));
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 100)
                                                  : $urandom_range(1, 25);
                run_phase(k, len, p, f);
            end
            cyc += len;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
